// File: rtl/ahb_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter_n_if
// Brief    : Request/grant/ownership bundle between AHB masters and arbiter.
// Revision : 1.0
// ============================================================================
interface ahb_arbiter_n_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [3:0]             HMASTER;
    logic                   HMASTLOCK;

    // Bus-side view: masters raise requests, slave returns HREADY.
    modport master (
        output HBUSREQ, HLOCK, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    // Arbiter-side view.
    modport slave (
        input  HBUSREQ, HLOCK, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface
`default_nettype wire

// File: rtl/ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter_n
// Brief    : N-master AHB-Lite arbiter, fixed-priority or round-robin, with
//            locked-transfer hold and optional tenure limit.
// Revision : 1.0
// ============================================================================
module ahb_arbiter_n #(
    parameter int NUM_MASTERS    = 2,
    parameter int MODE           = 0,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 0,
    parameter int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  wire logic     HCLK,
    input  wire logic     HRESET,
    ahb_arbiter_n_if.slave bus
);
    localparam int TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;

    localparam logic [MW-1:0]          C_DEF_IDX  = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] C_DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [TW-1:0]          C_MAX_T    = TW'(MAX_TENURE);
    localparam bit                     C_TENURE_EN = (MAX_TENURE != 0);

    logic [MW-1:0]          r_grant_idx;
    logic [NUM_MASTERS-1:0] r_grant_oh;
    logic [MW-1:0]          r_owner_idx;
    logic                   r_lock_q;
    logic [TW-1:0]          r_tenure;
    logic [MW-1:0]          r_rr_ptr;

    logic                   w_cur_req;
    logic                   w_cur_lock;
    logic                   w_hold;
    logic                   w_others;
    logic                   w_expired;
    logic [NUM_MASTERS-1:0] w_mask;
    logic [MW-1:0]          w_pick;
    logic [MW-1:0]          w_next_idx;
    logic                   w_change;

    assign w_cur_req  = bus.HBUSREQ[r_grant_idx];
    assign w_cur_lock = bus.HLOCK[r_grant_idx];
    assign w_hold     = w_cur_lock & w_cur_req;
    assign w_others   = |(bus.HBUSREQ & ~r_grant_oh);
    assign w_expired  = C_TENURE_EN && (r_tenure == C_MAX_T) && w_others;

    // On tenure expiry the current grantee is removed from the candidate set.
    assign w_mask = w_expired ? (bus.HBUSREQ & ~r_grant_oh) : bus.HBUSREQ;

    if (MODE == 1) begin : g_rr
        logic          w_found;
        logic [MW-1:0] w_cand;
        // Scan starts one past the last winner; the pointer itself is seen last.
        always_comb begin
            w_pick  = '0;
            w_found = 1'b0;
            w_cand  = '0;
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                w_cand = MW'((int'(r_rr_ptr) + i) % NUM_MASTERS);
                if (!w_found && w_mask[w_cand]) begin
                    w_pick  = w_cand;
                    w_found = 1'b1;
                end
            end
        end
    end else begin : g_fixed
        logic w_found;
        always_comb begin
            w_pick  = '0;
            w_found = 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!w_found && w_mask[MW'(i)]) begin
                    w_pick  = MW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_idx = r_grant_idx;
        if (w_hold) begin
            w_next_idx = r_grant_idx;
        end else if (|bus.HBUSREQ) begin
            w_next_idx = w_pick;
        end else begin
            w_next_idx = C_DEF_IDX;
        end
    end

    assign w_change = (w_next_idx != r_grant_idx);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant_idx <= C_DEF_IDX;
            r_grant_oh  <= C_DEF_OH;
            r_owner_idx <= C_DEF_IDX;
            r_lock_q    <= 1'b0;
            r_tenure    <= '0;
            r_rr_ptr    <= C_DEF_IDX;
        end else if (bus.HREADY) begin
            r_grant_idx <= w_next_idx;
            r_grant_oh  <= NUM_MASTERS'(1) << w_next_idx;
            r_owner_idx <= r_grant_idx;
            r_lock_q    <= w_hold;
            // Parking on the default master leaves the rotation point alone.
            if (w_change && bus.HBUSREQ[w_next_idx]) begin
                r_rr_ptr <= w_next_idx;
            end
            if (w_change) begin
                r_tenure <= '0;
            end else if (w_others && (r_tenure != C_MAX_T)) begin
                r_tenure <= r_tenure + TW'(1);
            end
        end
    end

    assign bus.HGRANT    = r_grant_oh;
    assign bus.HMASTER   = 4'(r_owner_idx);
    assign bus.HMASTLOCK = r_lock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_arbiter_n
// Brief    : Scoreboard bench for a fixed-priority and a round-robin arbiter.
// Revision : 1.0
// ============================================================================
module tb_ahb_arbiter_n;
    logic       HCLK;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic       rdy;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_arbiter_n_if #(.NUM_MASTERS(4)) fp_if ();
    ahb_arbiter_n_if #(.NUM_MASTERS(4)) rr_if ();

    assign fp_if.HBUSREQ = req;
    assign fp_if.HLOCK   = lck;
    assign fp_if.HREADY  = rdy;
    assign rr_if.HBUSREQ = req;
    assign rr_if.HLOCK   = lck;
    assign rr_if.HREADY  = rdy;

    ahb_arbiter_n #(.NUM_MASTERS(4), .MODE(0), .DEFAULT_MASTER(2), .MAX_TENURE(2)) u_fp (
        .HCLK(HCLK), .HRESET(rst), .bus(fp_if.slave)
    );
    ahb_arbiter_n #(.NUM_MASTERS(4), .MODE(1), .DEFAULT_MASTER(0), .MAX_TENURE(0)) u_rr (
        .HCLK(HCLK), .HRESET(rst), .bus(rr_if.slave)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference model: instance 0 = fixed priority, instance 1 = round robin.
    int cfg_mode [2] = '{0, 1};
    int cfg_def  [2] = '{2, 0};
    int cfg_maxt [2] = '{2, 0};
    int m_grant [2];
    int m_owner [2];
    int m_ten   [2];
    int m_rr    [2];
    bit m_lock  [2];

    typedef struct {
        logic [3:0] g;
        logic [3:0] m;
        logic       l;
    } exp_t;
    exp_t q_fp[$];
    exp_t q_rr[$];

    function automatic int pick(input logic [3:0] m, input int mode, input int rr);
        if (mode == 0) begin
            for (int i = 0; i < 4; i++) if (m[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (m[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int id);
        logic [3:0] oth;
        int   nxt;
        exp_t e;
        if (rst) begin
            m_grant[id] = cfg_def[id];
            m_owner[id] = cfg_def[id];
            m_lock[id]  = 1'b0;
            m_ten[id]   = 0;
            m_rr[id]    = cfg_def[id];
        end else if (rdy) begin
            oth = req & ~(4'b0001 << m_grant[id]);
            if (lck[m_grant[id]] && req[m_grant[id]])
                nxt = m_grant[id];
            else if (cfg_maxt[id] != 0 && m_ten[id] == cfg_maxt[id] && oth != 0)
                nxt = pick(oth, cfg_mode[id], m_rr[id]);
            else if (req != 0)
                nxt = pick(req, cfg_mode[id], m_rr[id]);
            else
                nxt = cfg_def[id];
            m_owner[id] = m_grant[id];
            m_lock[id]  = lck[m_grant[id]] && req[m_grant[id]];
            if (nxt != m_grant[id]) begin
                m_ten[id] = 0;
                if (req[nxt]) m_rr[id] = nxt;
            end else if (oth != 0 && m_ten[id] < cfg_maxt[id]) begin
                m_ten[id] = m_ten[id] + 1;
            end
            m_grant[id] = nxt;
        end
        e.g = 4'b0001 << m_grant[id];
        e.m = 4'(m_owner[id]);
        e.l = m_lock[id];
        if (id == 0) q_fp.push_back(e);
        else         q_rr.push_back(e);
    endtask

    initial forever begin
        @(posedge HCLK);
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic [3:0] g, input logic [3:0] m, input logic l);
        exp_t e;
        if (id == 0 && q_fp.size() == 0 || id == 1 && q_rr.size() == 0) begin
            chk(id == 0 ? "fp_queue_empty" : "rr_queue_empty", 32'd0, 32'd1);
            return;
        end
        e = (id == 0) ? q_fp.pop_front() : q_rr.pop_front();
        chk(id == 0 ? "fp_sb_grant"  : "rr_sb_grant",  32'(g), 32'(e.g));
        chk(id == 0 ? "fp_sb_master" : "rr_sb_master", 32'(m), 32'(e.m));
        chk(id == 0 ? "fp_sb_lock"   : "rr_sb_lock",   32'(l), 32'(e.l));
    endtask

    // Monitor: every cycle the DUT presents a grant/owner; compare at negedge.
    initial begin
        @(posedge HCLK);
        forever begin
            @(negedge HCLK);
            mon(0, fp_if.HGRANT, fp_if.HMASTER, fp_if.HMASTLOCK);
            mon(1, rr_if.HGRANT, rr_if.HMASTER, rr_if.HMASTLOCK);
        end
    end

    task automatic cyc();
        @(negedge HCLK);
    endtask

    int  rr_seq [5] = '{1, 2, 3, 0, 1};
    int  prev;
    bit  moved;

    initial begin
        rst = 1'b1; req = 4'b0; lck = 4'b0; rdy = 1'b1;
        cyc(); cyc();
        chk("rst_fp_grant",  32'(fp_if.HGRANT),    32'h4);
        chk("rst_fp_master", 32'(fp_if.HMASTER),   32'd2);
        chk("rst_fp_lock",   32'(fp_if.HMASTLOCK), 32'd0);
        chk("rst_rr_grant",  32'(rr_if.HGRANT),    32'h1);
        rst = 1'b0;
        cyc(); cyc();
        chk("idle_fp_grant",  32'(fp_if.HGRANT),  32'h4);
        chk("idle_fp_master", 32'(fp_if.HMASTER), 32'd2);

        // Fixed priority and pre-emption.
        req = 4'b1010;
        cyc();
        chk("fp_grant_1",   32'(fp_if.HGRANT),  32'h2);
        chk("fp_master_lag", 32'(fp_if.HMASTER), 32'd2);
        cyc();
        chk("fp_master_1",  32'(fp_if.HMASTER), 32'd1);
        req = 4'b1011;
        cyc();
        chk("fp_preempt",   32'(fp_if.HGRANT),  32'h1);

        // Round-robin rotation from a freshly reset pointer.
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_seq_grant",  32'(rr_if.HGRANT),  32'(4'b0001 << rr_seq[k]));
            chk("rr_seq_master", 32'(rr_if.HMASTER), 32'(prev));
            prev = rr_seq[k];
        end

        // Lock beats tenure; releasing the lock lets tenure expiry move the grant.
        req = 4'b1001; lck = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("lock_hold_grant", 32'(fp_if.HGRANT), 32'h1);
            if (i >= 1) chk("lock_mastlock", 32'(fp_if.HMASTLOCK), 32'd1);
        end
        lck = 4'b0000;
        moved = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (fp_if.HGRANT == 4'b1000) moved = 1'b1;
        end
        chk("lock_release_to_3", 32'(moved), 32'd1);

        // Wait states freeze grant and owner.
        req = 4'b0000;
        cyc(); cyc();
        req = 4'b0010; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wait_grant",  32'(fp_if.HGRANT),  32'h4);
            chk("wait_master", 32'(fp_if.HMASTER), 32'd2);
        end
        rdy = 1'b1;
        cyc();
        chk("wait_release_grant", 32'(fp_if.HGRANT), 32'h2);

        // Reset while master 3 owns a locked transfer.
        req = 4'b1000; lck = 4'b1000;
        cyc(); cyc();
        chk("lk3_master",   32'(fp_if.HMASTER),   32'd3);
        chk("lk3_mastlock", 32'(fp_if.HMASTLOCK), 32'd1);
        rst = 1'b1;
        cyc();
        chk("midrst_grant",  32'(fp_if.HGRANT),    32'h4);
        chk("midrst_master", 32'(fp_if.HMASTER),   32'd2);
        chk("midrst_lock",   32'(fp_if.HMASTLOCK), 32'd0);
        rst = 1'b0;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0) req = 4'($urandom_range(0, 15));
            lck = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; req = 4'b0; lck = 4'b0; rdy = 1'b1;
        cyc(); cyc();
        #2;
        chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);
        chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
